cpu_mem_ctrl: RTL

Memory controller directly downstream of the CPU core. It consumes the CPU's read and write request pulses (byte, half and word sizes, at any byte address) and turns them into accesses on a 32-bit synchronous single-port SRAM. It handles byte lanes and splits misaligned accesses into two word beats. It returns the result through the CPU's one-cycle ready handshake.

---
 rtl/cpu_mem_ctrl_if.sv | 46 ++++
 rtl/cpu_mem_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_ctrl_if.sv
// CPU request/ready handshake and SRAM port bundled for the memory controller.
interface cpu_mem_ctrl_if #(
  parameter int unsigned SRAM_AW = 16
) ();

  // CPU read channel
  logic [1:0]         m_in_sig_read;
  logic [31:0]        m_in_addr;
  logic [31:0]        m_in_data;
  logic               m_in_ready;

  // CPU write channel
  logic [1:0]         m_out_sig_write;
  logic [31:0]        m_out_addr;
  logic [31:0]        m_out_data;
  logic               m_out_ready;

  // Synchronous single-port SRAM
  logic               sram_en;
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [3:0]         sram_be;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;

  // Environment side: CPU requests plus the SRAM array
  modport master (
    output m_in_sig_read, m_in_addr,
    input  m_in_data, m_in_ready,
    output m_out_sig_write, m_out_addr, m_out_data,
    input  m_out_ready,
    input  sram_en, sram_we, sram_addr, sram_be, sram_wdata,
    output sram_rdata
  );

  // Controller side
  modport slave (
    input  m_in_sig_read, m_in_addr,
    output m_in_data, m_in_ready,
    input  m_out_sig_write, m_out_addr, m_out_data,
    output m_out_ready,
    output sram_en, sram_we, sram_addr, sram_be, sram_wdata,
    input  sram_rdata
  );

endinterface

// File: rtl/cpu_mem_ctrl.sv
// CPU-to-SRAM memory controller: byte/half/word accesses at any byte address,
// misaligned accesses split into two word beats, one-cycle ready pulses back to the CPU.
module cpu_mem_ctrl #(
  parameter int unsigned SRAM_AW = 16
) (
  input logic           clk,
  input logic           reset,
  cpu_mem_ctrl_if.slave bus
);

  // Byte-address bits that actually reach the SRAM; everything above wraps.
  localparam int unsigned AW = SRAM_AW + 2;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StRdDone,
    StWrA,
    StWrB,
    StWrDone
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Captured requests
  logic [1:0]    r_rd_size;
  logic [AW-1:0] r_rd_addr;
  logic [1:0]    r_wr_size;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic          r_wr_pend;

  // Read datapath and CPU-facing registers
  logic [31:0]   r_data_a;
  logic [31:0]   r_in_data;
  logic          r_in_ready;
  logic          r_out_ready;

  // Lane mask for a size code: 1=byte, 2=half, 3=word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Bit mask covering the low 8/16/32 bits of a size code.
  function automatic logic [31:0] data_mask(input logic [1:0] size);
    logic [3:0] m;
    m = size_mask(size);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // An access needs a second beat when it runs past the end of its first word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'd2) && (off == 2'd3)) || ((size == 2'd3) && (off != 2'd0));
  endfunction

  // ------------------------------------------------------------------
  // Address split and lane datapaths
  // ------------------------------------------------------------------
  logic [1:0]         w_rd_off;
  logic [SRAM_AW-1:0] w_rd_wa;
  logic [SRAM_AW-1:0] w_rd_wb;
  logic               w_rd_mis;
  logic [31:0]        w_rd_lo;
  logic [31:0]        w_rd_hi;
  logic [31:0]        w_rd_result;

  logic [1:0]         w_wr_off;
  logic [SRAM_AW-1:0] w_wr_wa;
  logic [SRAM_AW-1:0] w_wr_wb;
  logic               w_wr_mis;
  logic [63:0]        w_wr_d64;
  logic [7:0]         w_wr_m8;

  logic               w_unused;

  assign w_rd_off = r_rd_addr[1:0];
  assign w_rd_wa  = r_rd_addr[AW-1:2];
  assign w_rd_wb  = w_rd_wa + SRAM_AW'(1);
  assign w_rd_mis = misaligned(r_rd_size, w_rd_off);

  // In RD_DONE the live rdata is beat B when misaligned, otherwise the only beat.
  assign w_rd_lo     = w_rd_mis ? r_data_a : bus.sram_rdata;
  assign w_rd_hi     = w_rd_mis ? bus.sram_rdata : 32'd0;
  assign w_rd_result = 32'({w_rd_hi, w_rd_lo} >> {w_rd_off, 3'b000}) & data_mask(r_rd_size);

  assign w_wr_off = r_wr_addr[1:0];
  assign w_wr_wa  = r_wr_addr[AW-1:2];
  assign w_wr_wb  = w_wr_wa + SRAM_AW'(1);
  assign w_wr_mis = misaligned(r_wr_size, w_wr_off);
  assign w_wr_d64 = {32'd0, r_wr_data & data_mask(r_wr_size)} << {w_wr_off, 3'b000};
  assign w_wr_m8  = {4'd0, size_mask(r_wr_size)} << w_wr_off;

  // Upper address bits are ignored so the SRAM aliases across the byte space.
  assign w_unused = ^{bus.m_in_addr[31:AW], bus.m_out_addr[31:AW]};

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; a read wins over a simultaneous write
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (bus.m_in_sig_read != 2'd0) begin
          w_state_d = StRdA;
        end else if (bus.m_out_sig_write != 2'd0) begin
          w_state_d = StWrA;
        end
      end
      StRdA:    w_state_d = w_rd_mis ? StRdB : StRdDone;
      StRdB:    w_state_d = StRdDone;
      StRdDone: w_state_d = r_wr_pend ? StWrA : StIdle;
      StWrA:    w_state_d = w_wr_mis ? StWrB : StWrDone;
      StWrB:    w_state_d = StWrDone;
      StWrDone: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // SRAM port driven from the current state; idle and done states keep it quiet
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_be    = 4'b0000;
    bus.sram_wdata = 32'd0;
    case (r_state)
      StRdA: begin
        bus.sram_en   = 1'b1;
        bus.sram_addr = w_rd_wa;
        bus.sram_be   = 4'b1111;
      end
      StRdB: begin
        bus.sram_en   = 1'b1;
        bus.sram_addr = w_rd_wb;
        bus.sram_be   = 4'b1111;
      end
      StWrA: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = 1'b1;
        bus.sram_addr  = w_wr_wa;
        bus.sram_be    = w_wr_m8[3:0];
        bus.sram_wdata = w_wr_d64[31:0];
      end
      StWrB: begin
        bus.sram_en    = 1'b1;
        bus.sram_we    = 1'b1;
        bus.sram_addr  = w_wr_wb;
        bus.sram_be    = w_wr_m8[7:4];
        bus.sram_wdata = w_wr_d64[63:32];
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------

  // Read request capture, only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_size <= 2'd0;
      r_rd_addr <= '0;
    end else if ((r_state == StIdle) && (bus.m_in_sig_read != 2'd0)) begin
      r_rd_size <= bus.m_in_sig_read;
      r_rd_addr <= bus.m_in_addr[AW-1:0];
    end
  end

  // Write request capture; marked pending when a read arrived on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_size <= 2'd0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
      r_wr_pend <= 1'b0;
    end else if ((r_state == StIdle) && (bus.m_out_sig_write != 2'd0)) begin
      r_wr_size <= bus.m_out_sig_write;
      r_wr_addr <= bus.m_out_addr[AW-1:0];
      r_wr_data <= bus.m_out_data;
      r_wr_pend <= (bus.m_in_sig_read != 2'd0);
    end else if (r_state == StRdDone) begin
      r_wr_pend <= 1'b0;
    end
  end

  // Beat A read data is parked while beat B is fetched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_a <= 32'd0;
    end else if (r_state == StRdB) begin
      r_data_a <= bus.sram_rdata;
    end
  end

  // Read result held until the next read completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_data <= 32'd0;
    end else if (r_state == StRdDone) begin
      r_in_data <= w_rd_result;
    end
  end

  // One-cycle ready pulses leaving the DONE states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b0;
      r_out_ready <= 1'b0;
    end else begin
      r_in_ready  <= (r_state == StRdDone);
      r_out_ready <= (r_state == StWrDone);
    end
  end

  assign bus.m_in_data   = r_in_data;
  assign bus.m_in_ready  = r_in_ready;
  assign bus.m_out_ready = r_out_ready;

endmodule
